seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan scheduler for the calculator's common-anode 7-segment display.
- Owns the refresh prescaler: a free-running counter that wraps at TICK_MAX and issues a one-cycle tick.
- Sequences that tick into digit select, anti-ghost blanking and frame-aligned update of the displayed value.
- Sits between the calculator result register and the BCD-to-segment decoder.

---
 rtl/seg_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan scheduler for a common-anode 7-segment display.
// It owns the refresh prescaler, steps the digit select with anti-ghost blanking
// between digits, and commits new display data only on frame boundaries.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int TICK_MAX  = 31250,
  parameter int CNT_W     = 15,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic                  load_ack,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            digit_bcd,
  output logic                  dp_out,
  output logic                  frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BC_W  = $clog2(BLANK_CYC + 1);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic                 tick;
  logic [BC_W-1:0]      bc, bc_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [4*DIGITS-1:0]  disp, disp_n, pend;
  logic [DIGITS-1:0]    disp_dp, disp_dp_n, pend_dp;
  logic                 pend_valid;
  logic                 wrap, commit;
  logic [DIGITS-1:0]    lz_mask;
  logic                 zero_above;
  logic [3:0]           bcd_n;
  logic                 sup_n;

  assign tick   = (cnt == CNT_W'(TICK_MAX));
  assign wrap   = (state == BLANK) && (bc == '0) && (idx == IDX_W'(DIGITS - 1));
  assign commit = wrap && pend_valid;

  // Next scan state and the display contents that will be visible after this edge.
  always_comb begin
    state_n   = state;
    bc_n      = bc;
    idx_n     = idx;
    disp_n    = commit ? pend    : disp;
    disp_dp_n = commit ? pend_dp : disp_dp;
    case (state)
      SHOW: begin
        if (tick) begin
          state_n = BLANK;
          bc_n    = BC_W'(BLANK_CYC - 1);
        end
      end
      BLANK: begin
        if (bc == '0) begin
          state_n = SHOW;
          idx_n   = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
          bc_n = bc - 1'b1;
        end
      end
      default: state_n = SHOW;
    endcase
  end

  // Leading-zero mask: digit i is a leading zero when it and every higher digit are 0.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_n[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_above;
    end
  end

  // Select the nibble and suppression flag for the digit selected after this edge.
  always_comb begin
    bcd_n = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_n == IDX_W'(i)) bcd_n = disp_n[4*i +: 4];
    end
    sup_n = lz_en && lz_mask[idx_n];
  end

  // Registered state, buffers and outputs; outputs follow the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      state       <= SHOW;
      bc          <= '0;
      idx         <= '0;
      disp        <= '0;
      disp_dp     <= '0;
      pend        <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      an          <= '1;
      digit_bcd   <= '0;
      dp_out      <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt     <= tick ? '0 : cnt + 1'b1;
      state   <= state_n;
      bc      <= bc_n;
      idx     <= idx_n;
      disp    <= disp_n;
      disp_dp <= disp_dp_n;
      // A load on the commit edge lands in pending after the old contents were committed.
      if (load) begin
        pend       <= value_in;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      an          <= (state_n == SHOW && !sup_n) ? ~(DIGITS'(1) << idx_n) : '1;
      digit_bcd   <= bcd_n;
      dp_out      <= (state_n == SHOW) && !sup_n && disp_dp_n[idx_n];
      load_ack    <= commit;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench with a cycle-level reference model feeding an
// expected-output queue that is compared against the DUT after every clock.
module tb_seg_scan_ctrl;

  localparam int DIG = 4;
  localparam int TM  = 9;
  localparam int BC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic        load_ack;
  logic [3:0]  an;
  logic [3:0]  digit_bcd;
  logic        dp_out;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] bcd;
    logic       dp;
    logic       ack;
    logic       fs;
  } exp_t;

  exp_t q[$];

  // reference model state
  int          m_cnt, m_bc, m_idx;
  bit          m_show, m_pv;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dpd, m_pdp;
  exp_t        m_out;

  seg_scan_ctrl #(.DIGITS(DIG), .TICK_MAX(TM), .CNT_W(4), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in),
    .lz_en(lz_en), .load_ack(load_ack), .an(an), .digit_bcd(digit_bcd),
    .dp_out(dp_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge using the current inputs.
  task automatic m_step();
    bit wrapm, supp;
    if (rst) begin
      m_cnt = 0; m_bc = 0; m_idx = 0; m_show = 1; m_pv = 0;
      m_disp = '0; m_pend = '0; m_dpd = '0; m_pdp = '0;
      m_out = '{an: 4'hF, bcd: 4'h0, dp: 1'b0, ack: 1'b0, fs: 1'b0};
    end else begin
      wrapm     = !m_show && m_bc == 0 && m_idx == DIG - 1;
      m_out.ack = wrapm && m_pv;
      m_out.fs  = wrapm;
      if (m_out.ack) begin m_disp = m_pend; m_dpd = m_pdp; end
      if (load) begin m_pend = value_in; m_pdp = dp_in; m_pv = 1; end
      else if (m_out.ack) m_pv = 0;
      if (m_show) begin
        if (m_cnt == TM) begin m_show = 0; m_bc = BC - 1; end
      end else if (m_bc == 0) begin
        m_show = 1; m_idx = (m_idx + 1) % DIG;
      end else begin
        m_bc--;
      end
      m_cnt     = (m_cnt == TM) ? 0 : m_cnt + 1;
      supp      = lz_en && m_idx != 0 && ((m_disp >> (4 * m_idx)) == 16'h0);
      m_out.an  = (m_show && !supp) ? ~(4'b0001 << m_idx) : 4'hF;
      m_out.bcd = m_disp[4*m_idx +: 4];
      m_out.dp  = m_show && !supp && m_dpd[m_idx];
    end
  endtask

  task automatic cycle();
    exp_t e;
    m_step();
    q.push_back(m_out);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("an", 32'(an), 32'(e.an));
    chk("digit_bcd", 32'(digit_bcd), 32'(e.bcd));
    chk("dp_out", 32'(dp_out), 32'(e.dp));
    chk("load_ack", 32'(load_ack), 32'(e.ack));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
  endtask

  task automatic wait_ack(string tag, logic [3:0] exp_bcd);
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      cycle();
      if (load_ack) got = 1;
    end
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (got) chk({tag, "_bcd"}, 32'(digit_bcd), 32'(exp_bcd));
  endtask

  task automatic wait_an(string tag, logic [3:0] pat);
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      cycle();
      if (an == pat) got = 1;
    end
    chk({tag, "_reached"}, 32'(got), 32'd1);
  endtask

  task automatic seen_digits(string tag, logic [3:0] exp_seen);
    logic [3:0] seen = '0;
    for (int k = 0; k < 4 * (TM + 1); k++) begin
      cycle();
      seen = seen | ~an;
    end
    chk(tag, 32'(seen), 32'(exp_seen));
  endtask

  initial begin
    int n, fs_cnt, dp_cyc, dp_bad, acks, nz;
    bit got;

    // reset
    cycle();
    cycle();
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_bcd", 32'(digit_bcd), 32'h0);
    rst = 1'b0;

    // first digit dwell, blanking, next digit
    n = 0;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      cycle();
      if (an == 4'b1110) n++;
      else got = 1;
    end
    chk("first_show_len", 32'(n), 32'(TM));
    chk("blank1", 32'(an), 32'hF);
    cycle();
    chk("blank2", 32'(an), 32'hF);
    cycle();
    chk("slot1", 32'(an), 32'b1101);

    fs_cnt = 0;
    for (int k = 0; k < 3 * DIG * (TM + 1); k++) begin
      cycle();
      if (frame_start) fs_cnt++;
    end
    chk("frame_start_count", 32'(fs_cnt), 32'd3);

    // frame-aligned load during digit 1
    wait_an("to_digit1", 4'b1101);
    load = 1'b1; value_in = 16'h1234; dp_in = 4'b0000;
    cycle();
    load = 1'b0;
    chk("no_early_update", 32'(digit_bcd), 32'h0);
    wait_ack("commit1234", 4'h4);
    wait_an("to_digit2", 4'b1011);
    chk("digit2_value", 32'(digit_bcd), 32'h2);

    // overwrite then collision with the commit edge
    load = 1'b1; value_in = 16'h0011;
    cycle();
    value_in = 16'h0022;
    cycle();
    load = 1'b0;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (!m_show && m_bc == 0 && m_idx == DIG - 1) got = 1;
      else cycle();
    end
    chk("reach_commit_edge", 32'(got), 32'd1);
    load = 1'b1; value_in = 16'h0033;
    cycle();
    load = 1'b0;
    chk("collide_ack", 32'(load_ack), 32'd1);
    chk("collide_bcd", 32'(digit_bcd), 32'h2);
    wait_ack("commit33", 4'h3);

    // decimal point only on digit 2
    load = 1'b1; value_in = 16'h0123; dp_in = 4'b0100;
    cycle();
    load = 1'b0; dp_in = '0;
    wait_ack("commit0123", 4'h3);
    dp_cyc = 0;
    dp_bad = 0;
    for (int k = 0; k < DIG * (TM + 1); k++) begin
      cycle();
      if (dp_out) dp_cyc++;
      if (dp_out && an != 4'b1011) dp_bad++;
    end
    chk("dp_wrong_digit", 32'(dp_bad), 32'd0);
    chk("dp_present", 32'(dp_cyc != 0), 32'd1);

    // leading-zero suppression
    lz_en = 1'b1;
    load = 1'b1; value_in = 16'h0050;
    cycle();
    load = 1'b0;
    wait_ack("commit0050", 4'h0);
    seen_digits("lz_0050", 4'b0011);
    load = 1'b1; value_in = 16'h0000;
    cycle();
    load = 1'b0;
    wait_ack("commit0000", 4'h0);
    seen_digits("lz_0000", 4'b0001);
    lz_en = 1'b0;
    seen_digits("nolz_0000", 4'b1111);

    // reset in the blank after digit 2 discards a pending load
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      cycle();
      if (m_show && m_idx == 0) got = 1;
    end
    chk("reach_frame_begin", 32'(got), 32'd1);
    load = 1'b1; value_in = 16'h0999;
    cycle();
    load = 1'b0;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (!m_show && m_idx == 2) got = 1;
      else cycle();
    end
    chk("reach_blank2", 32'(got), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_ack", 32'(load_ack), 32'd0);
    acks = 0;
    nz = 0;
    for (int k = 0; k < 2 * DIG * (TM + 1); k++) begin
      cycle();
      if (load_ack) acks++;
      if (digit_bcd != 4'h0) nz++;
    end
    chk("midrst_no_ack", 32'(acks), 32'd0);
    chk("midrst_disp_zero", 32'(nz), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
